// File: rtl/pwm_pkg.sv
// pwm_mac shared types and helpers.
// Enums, beat-count helper and modular add.
package pwm_pkg;

  typedef enum logic {
    PWM_MUL = 1'b0,
    PWM_MAC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic int depth(
    input int poly_len,
    input int lanes
  );
    return poly_len / lanes;
  endfunction

  // Both operands are already reduced, so one
  // conditional subtract brings the sum below q.
  function automatic int unsigned mod_add(
    input int unsigned x,
    input int unsigned y,
    input int unsigned q
  );
    int unsigned s;
    s = x + y;
    if (s >= q) s = s - q;
    return s;
  endfunction

endpackage

// File: rtl/pwm_mac_if.sv
// pwm_mac job control and coefficient stream.
// master drives jobs/beats, slave is the engine.
interface pwm_mac_if #(
  parameter int DATA_WIDTH = 12,
  parameter int LANES      = 2,
  parameter int K_MAX      = 4
);
  localparam int KW = $clog2(K_MAX + 1);

  logic                              start;
  logic                              mode;
  logic [KW-1:0]                     cfg_k;
  logic                              busy;
  logic                              in_en;
  logic [LANES-1:0][DATA_WIDTH-1:0]  in_a;
  logic [LANES-1:0][DATA_WIDTH-1:0]  in_b;
  logic                              out_en;
  logic [LANES-1:0][DATA_WIDTH-1:0]  out;
  logic                              done;

  modport master (
    output start, mode, cfg_k,
    output in_en, in_a, in_b,
    input  busy, out_en, out, done
  );

  modport slave (
    input  start, mode, cfg_k,
    input  in_en, in_a, in_b,
    output busy, out_en, out, done
  );
endinterface

// File: rtl/pwm_modmul.sv
// Pipelined (a*b) mod Q, latency MUL_LAT.
// Free-running; validity is tracked by the caller.
module pwm_modmul #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] p_o
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] QW = PW'(Q);

  if (MUL_LAT < 2) begin : g_chk_lat
    $error("pwm_modmul: MUL_LAT must be >= 2");
  end

  logic [PW-1:0]         prod_q;
  logic [DATA_WIDTH-1:0] pipe_q [1:MUL_LAT-1];

  // Raw product, then reduction, then delay taps.
  always_ff @(posedge clk) begin
    prod_q    <= a_i * b_i;
    pipe_q[1] <= DATA_WIDTH'(prod_q % QW);
    for (int i = 2; i < MUL_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p_o = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/pwm_mac.sv
// Pointwise multiply / multiply-accumulate engine.
// MUL emits a*b mod Q; MAC sums k products per index.
module pwm_mac
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int LANES      = 2,
  parameter int POLY_LEN   = 256,
  parameter int MUL_LAT    = 3,
  parameter int K_MAX      = 4
) (
  input logic      clk,
  input logic      rst,
  pwm_mac_if.slave bus
);
  localparam int DEPTH = depth(POLY_LEN, LANES);
  localparam int BW    = $clog2(DEPTH);
  localparam int KW    = $clog2(K_MAX + 1);

  if (DEPTH <= MUL_LAT + 1) begin : g_chk_depth
    $error("pwm_mac: DEPTH must exceed MUL_LAT+1");
  end
  if (POLY_LEN % LANES != 0) begin : g_chk_lanes
    $error("pwm_mac: LANES must divide POLY_LEN");
  end
  if (Q >= (1 << DATA_WIDTH)) begin : g_chk_q
    $error("pwm_mac: Q must fit DATA_WIDTH");
  end

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] vec_t;

  typedef struct packed {
    logic          v;
    logic [BW-1:0] idx;
    logic          first;
    logic          last;
  } tag_t;

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [KW-1:0] kc_q, kc_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [KW-1:0] poly_q, poly_d;
  logic          done_q, done_d;

  logic [KW-1:0] k_cfg;
  logic [KW-1:0] k_eff;
  logic          last_poly;
  logic          accept;

  tag_t tag_q [MUL_LAT];
  tag_t t_acc;
  vec_t prod;
  vec_t sum;
  vec_t acc_q [DEPTH];
  vec_t out_q;
  logic out_en_q;
  logic fin_q;

  assign k_eff     = (mode_q == PWM_MAC) ? kc_q : KW'(1);
  assign last_poly = (poly_q == k_eff - KW'(1));
  assign accept    = (state_q == RUN) && bus.in_en;
  assign t_acc     = tag_q[MUL_LAT-1];

  // Clamp requested k into 1..K_MAX.
  always_comb begin
    k_cfg = bus.cfg_k;
    unique case (1'b1)
      (bus.cfg_k == '0):         k_cfg = KW'(1);
      (bus.cfg_k > KW'(K_MAX)):  k_cfg = KW'(K_MAX);
      default:                   k_cfg = bus.cfg_k;
    endcase
  end

  // Job sequencing: next state and counters.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    kc_d    = kc_q;
    beat_d  = beat_q;
    poly_d  = poly_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          mode_d  = mode_e'(bus.mode);
          kc_d    = k_cfg;
          beat_d  = '0;
          poly_d  = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (beat_q == BW'(DEPTH - 1)) begin
            beat_d = '0;
            if (last_poly) state_d = DRAIN;
            else poly_d = poly_q + KW'(1);
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      DRAIN: begin
        if (fin_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= PWM_MUL;
      kc_q    <= '0;
      beat_q  <= '0;
      poly_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      kc_q    <= kc_d;
      beat_q  <= beat_d;
      poly_q  <= poly_d;
      done_q  <= done_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pwm_modmul #(
      .DATA_WIDTH (DATA_WIDTH),
      .Q          (Q),
      .MUL_LAT    (MUL_LAT)
    ) u_mul (
      .clk (clk),
      .a_i (bus.in_a[l]),
      .b_i (bus.in_b[l]),
      .p_o (prod[l])
    );
  end

  // Beat tags ride alongside the multiplier pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{v: accept, idx: beat_q,
                    first: (poly_q == '0),
                    last: last_poly};
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Poly 0 seeds the sum; later polys add to it.
  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (t_acc.first) begin
        sum[l] = prod[l];
      end else begin
        sum[l] = DATA_WIDTH'(mod_add(
          32'(acc_q[t_acc.idx][l]),
          32'(prod[l]), Q));
      end
    end
  end

  // Partial sums park in the buffer until the last poly.
  always_ff @(posedge clk) begin
    if (t_acc.v && !t_acc.last) begin
      acc_q[t_acc.idx] <= sum;
    end
  end

  // Final poly drives the output port instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      out_en_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      out_en_q <= t_acc.v && t_acc.last;
      fin_q    <= t_acc.v && t_acc.last &&
                  (t_acc.idx == BW'(DEPTH - 1));
      if (t_acc.v && t_acc.last) out_q <= sum;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.out_en = out_en_q;
  assign bus.out    = out_q;

endmodule

// File: tb/tb_pwm_mac.sv
// Directed bench for pwm_mac with an output scoreboard.
// Expected beats are queued at drive time.
module tb_pwm_mac;
  localparam int DW    = 12;
  localparam int Q     = 3329;
  localparam int LANES = 2;
  localparam int PLEN  = 256;
  localparam int LAT   = 3;
  localparam int KMAX  = 4;
  localparam int DEPTH = PLEN / LANES;

  typedef logic [LANES-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t   val;
    longint due;
    int     beat;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  int          done_cnt = 0;
  longint      done_cyc = 0;
  int          out_cnt = 0;
  vec_t        last_out = '0;
  longint      last_out_cyc = 0;
  int          cap100 = -1;
  int unsigned opa [KMAX][DEPTH][LANES];
  int unsigned opb [KMAX][DEPTH][LANES];

  pwm_mac_if #(
    .DATA_WIDTH (DW),
    .LANES      (LANES),
    .K_MAX      (KMAX)
  ) bus ();

  pwm_mac #(
    .DATA_WIDTH (DW),
    .Q          (Q),
    .LANES      (LANES),
    .POLY_LEN   (PLEN),
    .MUL_LAT    (LAT),
    .K_MAX      (KMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.out_en) begin
      out_cnt++;
      last_out = bus.out;
      last_out_cyc = cyc;
      chk("out_expected", longint'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("out_data", bus.out, mon_e.val);
        chk("out_latency", cyc, mon_e.due);
        if (mon_e.beat == 100) cap100 = int'(bus.out[0]);
      end
    end
  end

  function automatic vec_t model(input int kexp,
                                 input int j);
    vec_t        v;
    int unsigned s;
    for (int l = 0; l < LANES; l++) begin
      s = 0;
      for (int p = 0; p < kexp; p++) begin
        s = (s + (opa[p][j][l] * opb[p][j][l]) % Q) % Q;
      end
      v[l] = DW'(s);
    end
    return v;
  endfunction

  task automatic fill_rand(input int kexp);
    for (int p = 0; p < kexp; p++)
      for (int j = 0; j < DEPTH; j++)
        for (int l = 0; l < LANES; l++) begin
          opa[p][j][l] = $urandom_range(4095);
          opb[p][j][l] = $urandom_range(4095);
        end
  endtask

  task automatic fill_const(input int kexp,
                            input int unsigned a,
                            input int unsigned b0,
                            input int unsigned bstep);
    for (int p = 0; p < kexp; p++)
      for (int j = 0; j < DEPTH; j++)
        for (int l = 0; l < LANES; l++) begin
          opa[p][j][l] = a;
          opb[p][j][l] = b0 + bstep * p;
        end
  endtask

  task automatic run_job(input bit     m,
                         input int     cfgk,
                         input int     kexp,
                         input int     bub,
                         input bit     glitch,
                         input int     abort_at);
    exp_t e;
    int   d0;
    int   o0;
    d0 = done_cnt;
    o0 = out_cnt;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.cfg_k = 3'(cfgk);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int p = 0; p < kexp; p++) begin
      for (int j = 0; j < DEPTH; j++) begin
        while (bub > 0 && $urandom_range(99) < bub) begin
          bus.in_en = 1'b0;
          @(posedge clk); #1;
        end
        if (abort_at >= 0 && p == kexp - 1 &&
            j == abort_at) begin
          bus.in_en = 1'b0;
          rst = 1'b1;
          while (sb.size() > 0 && sb[$].due > cyc)
            void'(sb.pop_back());
          @(posedge clk); #1;
          chk("rst_out_en", bus.out_en, 0);
          chk("rst_busy", bus.busy, 0);
          chk("rst_done", bus.done, 0);
          rst = 1'b0;
          repeat (8) @(posedge clk);
          #1;
          chk("rst_no_done", done_cnt, d0);
          chk("rst_sb_empty", sb.size(), 0);
          return;
        end
        bus.in_en = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          bus.in_a[l] = DW'(opa[p][j][l]);
          bus.in_b[l] = DW'(opb[p][j][l]);
        end
        if (glitch && p == 0 && j == 10) begin
          bus.start = 1'b1;
          bus.mode  = ~m;
          bus.cfg_k = 3'd1;
        end
        if (p == kexp - 1) begin
          e.val  = model(kexp, j);
          e.due  = cyc + LAT + 1;
          e.beat = j;
          sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    bus.in_en = 1'b0;
    for (int n = 0; n < 400 && done_cnt == d0; n++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", done_cnt, d0 + 1);
    chk("done_after_last", done_cyc, last_out_cyc + 1);
    chk("out_beats", out_cnt - o0, DEPTH);
    chk("sb_drained", sb.size(), 0);
    chk("busy_at_end", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_single", done_cnt, d0 + 1);
  endtask

  initial begin
    int o0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.cfg_k = '0;
    bus.in_en = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_en", bus.out_en, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_out", bus.out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int j = 0; j < DEPTH; j++)
      for (int l = 0; l < LANES; l++) begin
        opa[0][j][l] = j;
        opb[0][j][l] = j;
      end
    run_job(1'b0, 3, 1, 0, 1'b0, -1);
    chk("mul_beat100", cap100, 13);
    repeat (2) @(posedge clk);
    #1;
    chk("out_hold", bus.out, last_out);

    fill_const(3, 1, 100, 100);
    run_job(1'b1, 3, 3, 0, 1'b0, -1);
    chk("mac3_lane0", last_out[0], 600);

    fill_const(2, 3328, 2, 0);
    run_job(1'b1, 2, 2, 0, 1'b0, -1);
    chk("wrap_lane1", last_out[1], 3325);

    fill_const(3, 1, 100, 100);
    run_job(1'b1, 3, 3, 50, 1'b0, -1);
    chk("bubble_lane1", last_out[1], 600);

    run_job(1'b1, 3, 3, 0, 1'b1, -1);
    chk("glitch_lane0", last_out[0], 600);

    o0 = out_cnt;
    bus.in_a = {12'd7, 12'd9};
    bus.in_b = {12'd5, 12'd3};
    bus.in_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    bus.in_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_no_out", out_cnt, o0);
    chk("idle_busy", bus.busy, 0);

    fill_rand(1);
    run_job(1'b1, 0, 1, 0, 1'b0, -1);

    fill_rand(4);
    run_job(1'b1, 7, 4, 0, 1'b0, -1);

    fill_rand(2);
    run_job(1'b1, 2, 2, 0, 1'b0, 40);

    fill_const(2, 1, 5, 0);
    run_job(1'b1, 2, 2, 0, 1'b0, -1);
    chk("post_rst_lane0", last_out[0], 10);
    chk("post_rst_lane1", last_out[1], 10);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
